// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage: default widths,
// FSM state encoding and the values written into MEM/WB on a bubble.
package mem_stage_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int RW_DEFAULT = 5;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_ACCESS = 2'd1,
        STATE_FLUSH  = 2'd2
    } state_e;

    // Fields cleared in MEM/WB while the stage is stalled, so nothing retires twice.
    localparam logic BUBBLE_WB_EN = 1'b0;
    localparam logic BUBBLE_HALT  = 1'b0;

endpackage

// File: rtl/memory_stage_if.sv
// Data-cache request bus between the memory stage (master) and the cache (slave).
//
// Handshake: req rises when the stage enters ACCESS and is held, together with
// write/addr/wr_data, until a cycle in which ready is high; the transfer
// completes on that clock edge and rd_data is sampled in the same cycle.
// ready while req is low has no effect. flush/flush_done follow the same
// hold-until-done rule for cache flushes.
interface memory_stage_if #(
    parameter int DW = mem_stage_pkg::DW_DEFAULT
);
    logic          req;
    logic          write;
    logic [DW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          ready;
    logic          flush;
    logic          flush_done;

    modport master (
        output req, write, addr, wr_data, flush,
        input  rd_data, ready, flush_done
    );

    modport slave (
        input  req, write, addr, wr_data, flush,
        output rd_data, ready, flush_done
    );
endinterface

// File: rtl/dcache_req_fsm.sv
// Cache request sequencer for the memory stage: tracks whether the op held in
// EX/MEM is a cache access or flush and produces req/flush and the stall.
// Optional FLUSH state is built only when DCACHE_FLUSH_EN is defined.
module dcache_req_fsm
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mem_valid,
    input  logic       cache_flush,
    input  logic       dc_ready,
    input  logic       dc_flush_done,
    output logic       dc_req,
    output logic       dc_flush,
    output logic       stall,
    output logic [1:0] state
);

    localparam logic [1:0] IDLE   = STATE_IDLE;
    localparam logic [1:0] ACCESS = STATE_ACCESS;
`ifdef DCACHE_FLUSH_EN
    localparam logic [1:0] FLUSH  = STATE_FLUSH;
`endif

    logic [1:0] state_q;
    logic [1:0] state_d;

    // Classify the op being captured; a memory op wins over a flush.
    always_comb begin
        state_d = IDLE;
        if (mem_valid) begin
            state_d = ACCESS;
        end
`ifdef DCACHE_FLUSH_EN
        else if (cache_flush) begin
            state_d = FLUSH;
        end
`endif
    end

    // State advances only on edges where EX/MEM captures a new op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (!stall) begin
            state_q <= state_d;
        end
    end

    // Request/flush strobes and the stall, all decoded from the current state.
    always_comb begin
        dc_req   = 1'b0;
        dc_flush = 1'b0;
        stall    = 1'b0;
        case (state_q)
            ACCESS: begin
                dc_req = 1'b1;
                stall  = ~dc_ready;
            end
`ifdef DCACHE_FLUSH_EN
            FLUSH: begin
                dc_flush = 1'b1;
                stall    = ~dc_flush_done;
            end
`endif
            default: begin
                dc_req   = 1'b0;
                dc_flush = 1'b0;
                stall    = 1'b0;
            end
        endcase
    end

`ifndef DCACHE_FLUSH_EN
    // Without the flush feature a flush is a plain NOP and flush_done is ignored.
    logic unused_flush;
    assign unused_flush = cache_flush ^ dc_flush_done;
`endif

    assign state = state_q;

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM latch, data-cache request via memory_stage_if,
// load-data / ALU-result mux into MEM/WB, and the MEM forwarding source.
// Optional cache flush support is enabled by defining DCACHE_FLUSH_EN.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  logic           iClk,
    input  logic           iRst_n,
    input  logic [DW-1:0]  iExuResult,
    input  logic [DW-1:0]  iMemData,
    input  logic           iMemValid,
    input  logic           iMemWrite,
    input  logic           iMemToReg,
    input  logic           iCacheFlush,
    input  logic [RW-1:0]  iWriteAddr,
    input  logic           iWriteEn,
    input  logic           iHalt,
    memory_stage_if.master dc,
    output logic           oStall,
    output logic [DW-1:0]  oForwardMem,
    output logic [DW-1:0]  oWbData,
    output logic [RW-1:0]  oWbAddr,
    output logic           oWbEn,
    output logic           oHalt,
    output logic [1:0]     oDbgState
);

    // EX/MEM latch fields
    logic [DW-1:0] ex_result;
    logic [DW-1:0] ex_mem_data;
    logic          ex_mem_write;
    logic          ex_mem_to_reg;
    logic [RW-1:0] ex_write_addr;
    logic          ex_write_en;
    logic          ex_halt;

    dcache_req_fsm u_fsm (
        .clk           (iClk),
        .rst_n         (iRst_n),
        .mem_valid     (iMemValid),
        .cache_flush   (iCacheFlush),
        .dc_ready      (dc.ready),
        .dc_flush_done (dc.flush_done),
        .dc_req        (dc.req),
        .dc_flush      (dc.flush),
        .stall         (oStall),
        .state         (oDbgState)
    );

    // Capture the EX results whenever the stage is free; hold them while stalled.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ex_result     <= '0;
            ex_mem_data   <= '0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_write_addr <= '0;
            ex_write_en   <= 1'b0;
            ex_halt       <= 1'b0;
        end else if (!oStall) begin
            ex_result     <= iExuResult;
            ex_mem_data   <= iMemData;
            ex_mem_write  <= iMemWrite;
            ex_mem_to_reg <= iMemToReg;
            ex_write_addr <= iWriteAddr;
            ex_write_en   <= iWriteEn;
            ex_halt       <= iHalt;
        end
    end

    // Retire into MEM/WB when the stage completes; insert a bubble while stalled.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oWbData <= '0;
            oWbAddr <= '0;
            oWbEn   <= 1'b0;
            oHalt   <= 1'b0;
        end else if (!oStall) begin
            oWbData <= ex_mem_to_reg ? dc.rd_data : ex_result;
            oWbAddr <= ex_write_addr;
            oWbEn   <= ex_write_en;
            oHalt   <= ex_halt;
        end else begin
            oWbEn   <= BUBBLE_WB_EN;
            oHalt   <= BUBBLE_HALT;
        end
    end

    // The ALU result doubles as the access address; forwarding never sees cache data.
    assign dc.addr      = ex_result;
    assign dc.write     = ex_mem_write;
    assign dc.wr_data   = ex_mem_data;
    assign oForwardMem  = ex_result;

endmodule
